main_fp: RTL and testbench

Single-precision (IEEE-754 binary32 layout) floating-point multiplier with a start/done handshake. A controller captures both operands and runs a sequential 24×24 significand multiplier. It then presents the packed product on `result`. The block sits behind a host that pulses `startFP` and waits for `doneFP`. It has no special-value handling: zero, infinity, NaN and denormals are not treated specially, and there is no rounding beyond truncation.

---
 rtl/main_fp_pkg.sv | 8 +
 rtl/main_fp_mult.sv | 49 ++++
 rtl/main_fp.sv | 56 +++++
 tb/tb_main_fp.sv | 127 ++++++++++++
 4 files changed

// File: rtl/main_fp_pkg.sv
// main_fp_pkg: shared state encodings and constants for the main_fp multiplier
package main_fp_pkg;
  typedef enum logic [2:0] {C_IDLE, C_INIT, C_LOADA, C_LOADB, C_CALC} ctrl_state_t;
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mul_state_t;
  localparam logic [7:0] EXP_ADJ = 8'h81;
  localparam int unsigned SIG_W = 24;
  localparam logic [4:0] MUL_STEPS = 5'd24;
endpackage

// File: rtl/main_fp_mult.sv
// mult_top: sequential shift-add 24x24 significand multiplier keeping the top 25 product bits
module mult_top
  import main_fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-2:0] a,
  input  logic [SIG_W-2:0] b,
  output logic [SIG_W:0]   out,
  output logic             done
);
  mul_state_t state, state_nxt;
  logic [SIG_W-1:0] mc;
  logic [2*SIG_W-1:0] acc;
  logic [4:0] cnt;
  logic [SIG_W:0] sum;
  // high half of acc accumulates partial sums, low half holds the remaining multiplier bits
  assign sum = {1'b0, acc[2*SIG_W-1:SIG_W]} + (acc[0] ? {1'b0, mc} : '0);
  assign done = state == M_DONE;
  always_comb begin
    state_nxt = state;
    unique case (state)
      M_IDLE:  state_nxt = start ? M_RUN : M_IDLE;
      M_RUN:   state_nxt = cnt == 5'd1 ? M_DONE : M_RUN;
      default: state_nxt = M_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= M_IDLE;
      mc    <= '0;
      acc   <= '0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      if (state == M_IDLE && start) begin
        mc  <= {1'b1, a};
        acc <= {{SIG_W{1'b0}}, 1'b1, b};
        cnt <= MUL_STEPS;
      end else if (state == M_RUN) begin
        acc <= {sum, acc[SIG_W-1:1]};
        cnt <= cnt - 5'd1;
      end
      if (state == M_DONE) out <= acc[2*SIG_W-1:SIG_W-1];
    end
  end
endmodule

// File: rtl/main_fp.sv
// main_fp: start/done controlled binary32 multiplier with truncated significand, no special values
module main_fp
  import main_fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startFP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        doneFP
);
  ctrl_state_t state, state_nxt;
  logic [31:0] a_reg, b_reg;
  logic load_a, load_b, start_mul, done_mul;
  logic [SIG_W:0] prod;
  logic [7:0] exp_sum;
  mult_top u_mult (
    .clk  (clk),
    .rst  (rst),
    .start(start_mul),
    .a    (a_reg[22:0]),
    .b    (b_reg[22:0]),
    .out  (prod),
    .done (done_mul)
  );
  always_comb begin
    state_nxt = state;
    unique case (state)
      C_IDLE:  state_nxt = startFP ? C_INIT : C_IDLE;
      C_INIT:  state_nxt = startFP ? C_INIT : C_LOADA;
      C_LOADA: state_nxt = C_LOADB;
      C_LOADB: state_nxt = C_CALC;
      C_CALC:  state_nxt = done_mul ? C_IDLE : C_CALC;
      default: state_nxt = C_IDLE;
    endcase
  end
  assign load_a    = state == C_LOADA;
  assign load_b    = state == C_LOADB;
  assign start_mul = state == C_CALC;
  assign doneFP    = state == C_IDLE;
  // EXP_ADJ is -127 mod 256; prod[24] bumps the exponent when the product is in [2,4)
  assign exp_sum = a_reg[30:23] + b_reg[30:23] + EXP_ADJ + {7'b0, prod[SIG_W]};
  assign result  = {a_reg[31] ^ b_reg[31], exp_sum, prod[SIG_W] ? prod[SIG_W-1:1] : prod[SIG_W-2:0]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= C_IDLE;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      state <= state_nxt;
      if (load_a) a_reg <= A;
      if (load_b) b_reg <= B;
    end
  end
endmodule

// File: tb/tb_main_fp.sv
// tb_main_fp: table-driven, scoreboarded bench for main_fp
module tb_main_fp;
  logic clk = 0, rst = 0, startFP = 0;
  logic [31:0] A = 0, B = 0, result;
  logic doneFP;
  int passed = 0, total = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  main_fp dut (
    .clk    (clk),
    .rst    (rst),
    .startFP(startFP),
    .A      (A),
    .B      (B),
    .result (result),
    .doneFP (doneFP)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [24:0] o;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    o = p[47:23];
    return {a[31] ^ b[31], a[30:23] + b[30:23] + 8'h81 + {7'b0, o[24]}, o[24] ? o[23:1] : o[22:0]};
  endfunction

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                     input int hold, input string name);
    int n;
    logic [31:0] prev;
    prev = result;
    @(negedge clk);
    A = a;
    B = b;
    startFP = 1;
    sb.push_back(exp);
    repeat (1 + hold) begin
      @(negedge clk);
      check({name, " init doneFP"}, {31'b0, doneFP}, 32'd0);
      if (hold > 0) check({name, " init result"}, result, prev);
    end
    startFP = 0;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) A = ~a;
      if (n == 2) B = ~b;
      if (n == 5) check({name, " busy doneFP"}, {31'b0, doneFP}, 32'd0);
    end while (!doneFP && n < 60);
    check({name, " latency"}, n, 32'd28);
    check({name, " result"}, result, sb.pop_front());
    @(negedge clk);
    check({name, " result hold"}, result, exp);
  endtask

  initial begin
    tbl.push_back('{32'h83C0_0000, 32'h7040_0000, 32'hB490_0000, "spec_hi"});
    tbl.push_back('{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, "one_two"});
    tbl.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, "1p5_sq"});
    tbl.push_back('{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, "m2_x3"});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 32'h4080_0000, "zeros"});
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      tbl.push_back('{ra, rb, model(ra, rb), $sformatf("rand%0d", i)});
    end

    repeat (3) @(negedge clk);
    check("reset doneFP", {31'b0, doneFP}, 32'd1);
    check("reset result", result, 32'h4080_0000);
    rst = 1;
    @(negedge clk);
    check("post-reset doneFP", {31'b0, doneFP}, 32'd1);

    foreach (tbl[i]) run(tbl[i].a, tbl[i].b, tbl[i].exp, 0, tbl[i].name);

    run(32'h4040_0000, 32'h4080_0000, 32'h4140_0000, 10, "hold");

    @(negedge clk);
    A = 32'h3FC0_0000;
    B = 32'h4000_0000;
    startFP = 1;
    @(negedge clk);
    startFP = 0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2;
    rst = 0;
    #1;
    check("abort doneFP", {31'b0, doneFP}, 32'd1);
    check("abort result", result, 32'h4080_0000);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("abort idle doneFP", {31'b0, doneFP}, 32'd1);
    check("abort idle result", result, 32'h4080_0000);
    run(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 0, "after_abort");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
